serial_bit_feeder: RTL and testbench

- Parallel-in, serial-out stage that sits directly upstream of the team's Moore sequence detector.
- Accepts a WIDTH-bit word through a valid/ready handshake.
- Emits the word one bit per clock on `dout`; `dout` drives the detector's `din` input.
- Supports an optional idle gap between frames, back-to-back streaming, and MSB- or LSB-first ordering.

---
 rtl/serial_bit_feeder_if.sv | 23 ++
 rtl/serial_bit_feeder.sv | 108 ++++++++++
 tb/tb_serial_bit_feeder.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/serial_bit_feeder_if.sv
// Load handshake and serial output bundle for serial_bit_feeder.
// master = upstream word source / downstream observer, slave = the feeder.
interface serial_bit_feeder_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             dout;
    logic             dout_valid;
    logic             busy;
    logic             frame_done;

    modport master (
        output data_in, load_valid,
        input  load_ready, dout, dout_valid, busy, frame_done
    );

    modport slave (
        input  data_in, load_valid,
        output load_ready, dout, dout_valid, busy, frame_done
    );
endinterface

// File: rtl/serial_bit_feeder.sv
// Parallel-in serial-out feeder for the sequence detector's din input.
//   state | meaning
//   IDLE  | no frame, dout = IDLE_BIT, ready for a word
//   SHIFT | one frame bit per cycle on dout, last bit pulses frame_done
//   GAP   | GAP_CYCLES idle cycles after a frame, ready on the last one
module serial_bit_feeder #(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 1,
    parameter int GAP_CYCLES = 0,
    parameter bit IDLE_BIT   = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    serial_bit_feeder_if.slave  bus
);
    localparam int CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;
    logic [3:0]       gap_cnt;

    logic last_bit;
    logic last_gap;
    logic accept;

    assign last_bit = (state == SHIFT) && (bit_cnt == BIT_LAST);
    assign last_gap = (state == GAP) && (gap_cnt == 4'd0);
    assign accept   = bus.load_valid && bus.load_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        bus.load_ready = 1'b0;
        bus.dout       = IDLE_BIT;
        bus.dout_valid = 1'b0;
        bus.frame_done = 1'b0;
        bus.busy       = (state != IDLE);
        case (state)
            IDLE: begin
                bus.load_ready = 1'b1;
                if (bus.load_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                bus.dout       = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
                bus.dout_valid = 1'b1;
                if (last_bit) begin
                    bus.frame_done = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        state_nxt = GAP;
                    end else begin
                        // Accepting here is what lets frames stream without a bubble.
                        bus.load_ready = 1'b1;
                        state_nxt      = bus.load_valid ? SHIFT : IDLE;
                    end
                end
            end
            GAP: begin
                if (last_gap) begin
                    bus.load_ready = 1'b1;
                    state_nxt      = bus.load_valid ? SHIFT : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= 4'd0;
        end else begin
            if (accept) begin
                shreg   <= bus.data_in;
                bit_cnt <= '0;
            end else if (state == SHIFT) begin
                if (MSB_FIRST != 0) begin
                    shreg <= {shreg[WIDTH-2:0], 1'b0};
                end else begin
                    shreg <= {1'b0, shreg[WIDTH-1:1]};
                end
                if (!last_bit) bit_cnt <= bit_cnt + CW'(1);
            end

            if (last_bit) begin
                gap_cnt <= 4'(GAP_LAST);
            end else if ((state == GAP) && (gap_cnt != 4'd0)) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: three instances cover MSB/no-gap,
// MSB/two-cycle gap and LSB-first orderings with hand-computed bit streams.
module tb_serial_bit_feeder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_bit_feeder_if #(.WIDTH(4)) if_a ();
    serial_bit_feeder_if #(.WIDTH(4)) if_b ();
    serial_bit_feeder_if #(.WIDTH(4)) if_c ();

    serial_bit_feeder #(.WIDTH(4), .MSB_FIRST(1), .GAP_CYCLES(0), .IDLE_BIT(1'b0))
        u_a (.clk(clk), .reset(reset), .bus(if_a));
    serial_bit_feeder #(.WIDTH(4), .MSB_FIRST(1), .GAP_CYCLES(2), .IDLE_BIT(1'b0))
        u_b (.clk(clk), .reset(reset), .bus(if_b));
    serial_bit_feeder #(.WIDTH(4), .MSB_FIRST(0), .GAP_CYCLES(0), .IDLE_BIT(1'b0))
        u_c (.clk(clk), .reset(reset), .bus(if_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
            $error("check %s", tag);
        end
    endtask

    task automatic exp_a(input string tag, input logic d, input logic dv,
                         input logic fd, input logic rdy, input logic bz);
        chk({tag, ".a.dout"}, if_a.dout, d);
        chk({tag, ".a.dout_valid"}, if_a.dout_valid, dv);
        chk({tag, ".a.frame_done"}, if_a.frame_done, fd);
        chk({tag, ".a.load_ready"}, if_a.load_ready, rdy);
        chk({tag, ".a.busy"}, if_a.busy, bz);
    endtask

    task automatic exp_b(input string tag, input logic d, input logic dv,
                         input logic fd, input logic rdy, input logic bz);
        chk({tag, ".b.dout"}, if_b.dout, d);
        chk({tag, ".b.dout_valid"}, if_b.dout_valid, dv);
        chk({tag, ".b.frame_done"}, if_b.frame_done, fd);
        chk({tag, ".b.load_ready"}, if_b.load_ready, rdy);
        chk({tag, ".b.busy"}, if_b.busy, bz);
    endtask

    task automatic exp_c(input string tag, input logic d, input logic dv,
                         input logic fd, input logic rdy, input logic bz);
        chk({tag, ".c.dout"}, if_c.dout, d);
        chk({tag, ".c.dout_valid"}, if_c.dout_valid, dv);
        chk({tag, ".c.frame_done"}, if_c.frame_done, fd);
        chk({tag, ".c.load_ready"}, if_c.load_ready, rdy);
        chk({tag, ".c.busy"}, if_c.busy, bz);
    endtask

    initial begin
        logic [3:0] w4;
        logic [7:0] w8;
        int         j;

        if_a.data_in = 4'h0; if_a.load_valid = 1'b0;
        if_b.data_in = 4'h0; if_b.load_valid = 1'b0;
        if_c.data_in = 4'h0; if_c.load_valid = 1'b0;

        // reset state
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        exp_a("rst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_b("rst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_c("rst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // single MSB-first frame 1011
        w4 = 4'b1011;
        if_a.data_in = w4; if_a.load_valid = 1'b1;
        tick();
        if_a.load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_a($sformatf("single.b%0d", i), w4[3-i], 1'b1, (i == 3), (i == 3), 1'b1);
            tick();
        end
        exp_a("single.idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // back-to-back B then 6 with no bubble
        w8 = 8'hB6;
        if_a.data_in = 4'hB; if_a.load_valid = 1'b1;
        tick();
        if_a.data_in = 4'h6;
        for (int i = 0; i < 8; i++) begin
            exp_a($sformatf("b2b.b%0d", i), w8[7-i], 1'b1, (i == 3 || i == 7),
                  (i == 3 || i == 7), 1'b1);
            tick();
            if (i == 3) if_a.load_valid = 1'b0;
        end
        exp_a("b2b.idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // load pulsed mid-frame is ignored
        w4 = 4'b1001;
        if_a.data_in = w4; if_a.load_valid = 1'b1;
        tick();
        if_a.load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                if_a.data_in = 4'hF; if_a.load_valid = 1'b1;
            end
            exp_a($sformatf("ign.b%0d", i), w4[3-i], 1'b1, (i == 3), (i == 3), 1'b1);
            tick();
            if_a.load_valid = 1'b0;
        end
        exp_a("ign.idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        exp_a("ign.idle2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // reset at bit 2 aborts the frame, next word comes out intact
        w4 = 4'b1101;
        if_a.data_in = w4; if_a.load_valid = 1'b1;
        tick();
        if_a.load_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_a($sformatf("abort.b%0d", i), w4[3-i], 1'b1, 1'b0, 1'b0, 1'b1);
            if (i < 2) tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_a("abort.after", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        w4 = 4'b1010;
        if_a.data_in = w4; if_a.load_valid = 1'b1;
        tick();
        if_a.load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_a($sformatf("post.b%0d", i), w4[3-i], 1'b1, (i == 3), (i == 3), 1'b1);
            tick();
        end
        exp_a("post.idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // gap insertion with load_valid held: 4 bits, 2 idle, repeat
        w4 = 4'b0101;
        if_b.data_in = w4; if_b.load_valid = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            j = i % 6;
            if (j < 4) begin
                exp_b($sformatf("gap.c%0d", i), w4[3-j], 1'b1, (j == 3), 1'b0, 1'b1);
            end else begin
                exp_b($sformatf("gap.c%0d", i), 1'b0, 1'b0, 1'b0, (j == 5), 1'b1);
            end
            if (i == 11) if_b.load_valid = 1'b0;
            tick();
        end
        exp_b("gap.idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // LSB-first ordering
        w4 = 4'b0001;
        if_c.data_in = w4; if_c.load_valid = 1'b1;
        tick();
        if_c.load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_c($sformatf("lsb1.b%0d", i), w4[i], 1'b1, (i == 3), (i == 3), 1'b1);
            tick();
        end
        exp_c("lsb1.idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        w4 = 4'b0110;
        if_c.data_in = w4; if_c.load_valid = 1'b1;
        tick();
        if_c.load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_c($sformatf("lsb2.b%0d", i), w4[i], 1'b1, (i == 3), (i == 3), 1'b1);
            tick();
        end
        exp_c("lsb2.idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
